// File: rtl/i2c_slave_core.sv
// I2C target: filtered SCL/SDA, 7-bit address match, byte receive/transmit
// with ACK handling. SDA is open-drain (sda_oe_o=1 pulls the line low).
// Ports:
//   i2c_core_clk_i/i2c_core_rst_i : core clock, sync active-high reset
//   scl_i/sda_i/sda_oe_o          : bus levels in, SDA pull-down out
//   slave_addr_i                  : own 7-bit address
//   tx_data_i/tx_rd_o             : read byte source and its capture pulse
//   rx_data_o/rx_valid_o/rx_full_i: written byte sink and back-pressure
//   start_o/stop_o/rw_o/busy_o    : bus status
module i2c_slave_core #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 2
) (
  input  logic       i2c_core_clk_i,
  input  logic       i2c_core_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic [6:0] slave_addr_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_rd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_full_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       rw_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK,
    WR_NACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [FILTER_CYC-1:0]  scl_hist, sda_hist;
  logic scl_f, sda_f, scl_p, sda_p;

  // Chains preset to 1 so a reset looks like an idle bus.
  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_hist <= {scl_hist[FILTER_CYC-2:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[FILTER_CYC-2:0], sda_sync[SYNC_STAGES-1]};
      if (&scl_hist) scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist) sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  logic scl_r, scl_fe, start_ev, stop_ev;
  assign scl_r    = scl_f & ~scl_p;
  assign scl_fe   = ~scl_f & scl_p;
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, tx_q, tx_d, rx_q, rx_d;
  logic       phase_q, phase_d;
  logic       oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
  logic       rxv_q, rxv_d, txr_q, txr_d;
  logic       sta_q, sta_d, sto_q, sto_d;
  logic [7:0] byte_in;

  assign byte_in = {sh_q[6:0], sda_f};

  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_core_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      phase_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      rxv_q   <= 1'b0;
      txr_q   <= 1'b0;
      sta_q   <= 1'b0;
      sto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      phase_q <= phase_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      rxv_q   <= rxv_d;
      txr_q   <= txr_d;
      sta_q   <= sta_d;
      sto_q   <= sto_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    phase_d = phase_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    rxv_d   = 1'b0;
    txr_d   = 1'b0;
    sta_d   = 1'b0;
    sto_d   = 1'b0;
    if (stop_ev) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      sto_d   = 1'b1;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (start_ev) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      sta_d   = 1'b1;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, WR_DATA: begin
          if (scl_r) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ADDR) begin
                // Address 0 (general call) is treated as a miss.
                if (byte_in[7:1] == slave_addr_i && byte_in[7:1] != '0) begin
                  rw_d    = byte_in[0];
                  state_d = ADDR_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = WAIT_STOP;
                end
              end else if (rx_full_i) begin
                state_d = WR_NACK;
              end else begin
                rx_d    = byte_in;
                rxv_d   = 1'b1;
                state_d = WR_ACK;
              end
            end
          end
        end
        // phase 0: SCL_F ending bit 8 -> pull ACK;
        // phase 1: SCL_F ending ACK -> hand over.
        ADDR_ACK, WR_ACK: begin
          if (scl_fe) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                tx_d    = tx_data_i;
                txr_d   = 1'b1;
                oe_d    = ~tx_data_i[7];
                cnt_d   = '0;
                state_d = RD_DATA;
              end else begin
                oe_d    = 1'b0;
                state_d = WR_DATA;
              end
            end
          end
        end
        WR_NACK: begin
          if (scl_fe) begin
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end
        RD_DATA: begin
          if (scl_r) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fe) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = RD_ACK;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_r) begin
            if (sda_f) begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end else if (scl_fe) begin
            tx_d    = tx_data_i;
            txr_d   = 1'b1;
            oe_d    = ~tx_data_i[7];
            cnt_d   = '0;
            state_d = RD_DATA;
          end
        end
        WAIT_STOP: begin
          oe_d   = 1'b0;
          busy_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe_o   = oe_q;
  assign tx_rd_o    = txr_q;
  assign rx_data_o  = rx_q;
  assign rx_valid_o = rxv_q;
  assign start_o    = sta_q;
  assign stop_o     = sto_q;
  assign rw_o       = rw_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bus-level master, transaction model and an
// event scoreboard checked by an independent monitor.
module tb_i2c_slave_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda;
  logic       sda_oe, tx_rd, rx_valid, start, stop, rw, busy;
  logic [6:0] own = 7'h61;
  logic [7:0] tx_data, rx_data;
  logic       rx_full = 1'b0;

  assign sda = sda_m & ~sda_oe;

  i2c_slave_core dut (
    .i2c_core_clk_i(clk),
    .i2c_core_rst_i(rst),
    .scl_i(scl),
    .sda_i(sda),
    .sda_oe_o(sda_oe),
    .slave_addr_i(own),
    .tx_data_i(tx_data),
    .tx_rd_o(tx_rd),
    .rx_data_o(rx_data),
    .rx_valid_o(rx_valid),
    .rx_full_i(rx_full),
    .start_o(start),
    .stop_o(stop),
    .rw_o(rw),
    .busy_o(busy)
  );

  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_RX    = 2;
  localparam int EV_TX    = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] wr_data[8];
  logic [7:0] rd_data[8];
  int         rd_cnt = 0;
  int         rd_base = 0;
  bit         rep_pending = 0;

  assign tx_data = rd_data[3'(rd_cnt - rd_base)];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int kind, logic [7:0] data);
    exp_q.push_back('{kind: kind, data: data});
  endtask

  task automatic pop_chk(int kind, logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", kind, e.kind);
      if (kind == EV_RX) chk("rx data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (start) pop_chk(EV_START, 8'h00);
      if (rx_valid) pop_chk(EV_RX, rx_data);
      if (tx_rd) begin
        pop_chk(EV_TX, 8'h00);
        rd_cnt++;
      end
      if (stop) pop_chk(EV_STOP, 8'h00);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    cyc(10);
    scl = 1'b1;
    cyc(10);
    r = sda;
    cyc(10);
    scl = 1'b0;
    cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic r;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      b = {b[6:0], r};
    end
    bit_io(nack, r);
  endtask

  task automatic do_start(input bit rep);
    if (rep) begin
      sda_m = 1'b1;
      cyc(10);
      scl = 1'b1;
      cyc(20);
    end
    sda_m = 1'b0;
    cyc(20);
    scl = 1'b0;
    cyc(10);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    cyc(10);
    scl = 1'b1;
    cyc(20);
    sda_m = 1'b1;
    cyc(20);
  endtask

  // One transaction: expected events derived from the addressing and
  // ACK rules, bus responses checked as the master sees them.
  task automatic txn(input logic [6:0] own_a, input logic [7:0] ab,
                     input int n, input int full_at, input bit rep_next);
    logic       ack;
    logic [7:0] b;
    bit         match, dropped;
    own = own_a;
    rd_base = rd_cnt;
    match = (ab[7:1] == own_a) && (ab[7:1] != 7'd0);
    dropped = 0;
    push(EV_START, 8'h00);
    if (match && ab[0]) push(EV_TX, 8'h00);
    do_start(rep_pending);
    send_byte(ab, ack);
    chk("addr ack", ack, !match);
    if (match) begin
      chk("busy after addr", busy, 1);
      chk("rw", rw, ab[0]);
      if (!ab[0]) begin
        for (int i = 0; i < n; i++) begin
          rx_full = (i == full_at);
          if (!dropped && !rx_full) push(EV_RX, wr_data[i]);
          send_byte(wr_data[i], ack);
          chk("data ack", ack, dropped || (i == full_at));
          if (i == full_at) dropped = 1;
          rx_full = 1'b0;
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          if (i < n - 1) push(EV_TX, 8'h00);
          recv_byte(b, i == n - 1);
          chk("read byte", b, rd_data[i]);
        end
      end
    end
    if (!rep_next) begin
      push(EV_STOP, 8'h00);
      do_stop();
      chk("busy after stop", busy, 0);
    end
    rep_pending = rep_next;
  endtask

  initial begin
    logic       ack;
    logic [6:0] o;
    logic [7:0] ab;
    int         n, fa;
    bit         rwb;
    for (int i = 0; i < 8; i++) begin
      wr_data[i] = '0;
      rd_data[i] = '0;
    end
    rst = 1'b1;
    cyc(5);
    chk("reset outputs",
        {sda_oe, tx_rd, rx_valid, rx_data, start, stop, rw, busy}, 0);
    rst = 1'b0;
    cyc(30);

    wr_data[0] = 8'h0B;
    wr_data[1] = 8'h0C;
    wr_data[2] = 8'h0D;
    txn(7'h61, 8'hC2, 3, -1, 0);
    txn(7'h61, 8'hC4, 0, -1, 0);
    txn(7'h61, 8'h00, 0, -1, 0);
    rd_data[0] = 8'hA5;
    rd_data[1] = 8'h3C;
    txn(7'h61, 8'hC3, 2, -1, 0);
    wr_data[0] = 8'h11;
    wr_data[1] = 8'h22;
    wr_data[2] = 8'h33;
    txn(7'h61, 8'hC2, 3, 1, 0);
    wr_data[0] = 8'h55;
    txn(7'h61, 8'hC2, 1, -1, 1);
    rd_data[0] = 8'h96;
    txn(7'h61, 8'hC3, 1, -1, 0);

    // Reset while the target pulls SDA for a 0 data bit.
    own = 7'h61;
    rd_base = rd_cnt;
    rd_data[0] = 8'h5A;
    push(EV_START, 8'h00);
    push(EV_TX, 8'h00);
    do_start(0);
    send_byte(8'hC3, ack);
    chk("rst addr ack", ack, 0);
    chk("rst msb driven", sda_oe, 1);
    rst = 1'b1;
    cyc(1);
    chk("mid reset outputs",
        {sda_oe, tx_rd, rx_valid, rx_data, start, stop, rw, busy}, 0);
    rst = 1'b0;
    cyc(10);
    push(EV_STOP, 8'h00);
    do_stop();
    chk("busy after reset stop", busy, 0);
    wr_data[0] = 8'hE7;
    wr_data[1] = 8'h18;
    txn(7'h61, 8'hC2, 2, -1, 0);

    for (int t = 0; t < 12; t++) begin
      o = 7'($urandom_range(1, 127));
      rwb = 1'($urandom);
      ab = ($urandom % 3 != 0) ? {o, rwb} : 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        wr_data[i] = 8'($urandom);
        rd_data[i] = 8'($urandom);
      end
      fa = (!ab[0] && $urandom % 3 == 0) ? $urandom_range(0, n - 1) : -1;
      txn(o, ab, n, fa, (t < 11) && ($urandom % 4 == 0));
    end

    cyc(50);
    chk("events left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
